// File: rtl/imem_boot_loader.sv
// ============================================================================
// Module   : imem_boot_loader
// Brief    : Packs a length-prefixed byte stream into 32-bit instruction words
//            and holds the core in reset until the image is written.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_boot_loader #(
    parameter int ADDR_W = 10               // 1..15; word count N is 16 bits
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [16:0] c_DEPTH = 17'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_LEN0 = 3'd0,
        S_LEN1 = 3'd1,
        S_DATA = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_n_lo;
    logic [15:0]       r_n;
    logic [1:0]        r_b;
    logic [23:0]       r_word;
    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_core_rst;
    logic [ADDR_W:0]   r_words;

    logic              w_xfer;
    logic [15:0]       w_n_hdr;
    logic [16:0]       w_words_ext;
    logic              w_word_done;
    logic              w_last;

    assign w_xfer      = in_valid & r_in_ready;
    assign w_n_hdr     = {in_data, r_n_lo};
    assign w_words_ext = 17'(r_words);
    assign w_word_done = w_xfer && (r_state == S_DATA) && (r_b == 2'd3);
    assign w_last      = ((w_words_ext + 17'd1) == {1'b0, r_n});

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LEN0: if (w_xfer) w_next = S_LEN1;
            S_LEN1: begin
                if (w_xfer) begin
                    if (w_n_hdr == 16'd0)
                        w_next = S_DONE;
                    else if ({1'b0, w_n_hdr} > c_DEPTH)
                        w_next = S_ERR;
                    else
                        w_next = S_DATA;
                end
            end
            S_DATA: if (w_word_done && w_last) w_next = S_DONE;
            S_DONE: if (reload) w_next = S_LEN0;
            S_ERR:  if (reload) w_next = S_LEN0;
            default: w_next = S_LEN0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_LEN0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_core_rst  <= 1'b1;
            r_words     <= '0;
            r_b         <= 2'd0;
            r_word      <= '0;
            r_n_lo      <= '0;
            r_n         <= '0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next == S_LEN0) || (w_next == S_LEN1) || (w_next == S_DATA);
            r_mem_we   <= w_word_done;
            // Release the core only once the final write pulse has been issued
            r_core_rst <= !((r_state == S_DONE) && (w_next == S_DONE));

            if (w_xfer && (r_state == S_LEN0)) r_n_lo <= in_data;
            if (w_xfer && (r_state == S_LEN1)) r_n    <= w_n_hdr;

            if (w_xfer && (r_state == S_DATA)) begin
                r_b <= r_b + 2'd1;
                case (r_b)
                    2'd0: r_word[7:0]   <= in_data;
                    2'd1: r_word[15:8]  <= in_data;
                    2'd2: r_word[23:16] <= in_data;
                    default: begin
                        r_mem_addr  <= r_words[ADDR_W-1:0];
                        r_mem_wdata <= {in_data, r_word};
                        r_words     <= r_words + 1'b1;
                    end
                endcase
            end

            if (((r_state == S_DONE) || (r_state == S_ERR)) && reload) begin
                r_words <= '0;
                r_b     <= 2'd0;
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign core_rst     = r_core_rst;
    assign done         = (r_state == S_DONE);
    assign err          = (r_state == S_ERR);
    assign words_loaded = r_words;

endmodule

`default_nettype wire
